// File: rtl/ws2812b_ctrl.sv
// WS2812B LED strip driver: register-mapped pixel buffer, bit-serial waveform generator and latch timer.
// Optional continuous refresh is compiled in with `define WS2812_LOOP_EN (CTRL bit2 = loop).
module ws2812b_ctrl #(
    parameter int NUM_LEDS = 8,
    parameter int T0H      = 26,
    parameter int T1H      = 51,
    parameter int TBIT     = 80,
    parameter int TRST     = 19200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    localparam int         TMAX    = (TRST > TBIT) ? TRST : TBIT;
    localparam int         TW      = $clog2(TMAX);
    localparam logic [7:0] NL8     = 8'(NUM_LEDS);
    localparam logic [3:0] LAST_IX = 4'(NUM_LEDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BIT, S_LATCH} state_t;

    state_t          state_q, state_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            loop_q, loop_d;
    logic [3:0]      index_q, index_d;
    logic [7:0]      count_q, count_d;
    logic [7:0]      g_q, g_d;
    logic [7:0]      r_q, r_d;
    logic [3:0]      pix_q, pix_d;
    logic [3:0]      last_q, last_d;
    logic [23:0]     shift_q, shift_d;
    logic [4:0]      bitn_q, bitn_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            led_q, led_d;

    // Sized to the full 4-bit index space; slots at or above NUM_LEDS are never written.
    logic [15:0][23:0] buf_q;
    logic              buf_we;
    logic [23:0]       buf_wdata;

    logic [7:0]    eff_m1;
    logic [TW-1:0] thigh;

    always_comb begin
        if (count_q == 8'd0 || count_q > NL8) eff_m1 = NL8 - 8'd1;
        else                                  eff_m1 = count_q - 8'd1;
    end

    assign thigh = shift_q[23] ? TW'(T1H) : TW'(T0H);

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        loop_d    = loop_q;
        index_d   = index_q;
        count_d   = count_q;
        g_d       = g_q;
        r_d       = r_q;
        pix_d     = pix_q;
        last_d    = last_q;
        shift_d   = shift_q;
        bitn_d    = bitn_q;
        tmr_d     = tmr_q;
        led_d     = 1'b0;
        buf_we    = 1'b0;
        buf_wdata = {g_q, r_q, data_in};

        // Register writes; clear is applied before start so CTRL=0x03 restarts cleanly.
        if (data_write) begin
            case (address)
                4'h0: begin
                    if (data_in[1]) begin
                        done_d = 1'b0;
                        err_d  = 1'b0;
                    end
`ifdef WS2812_LOOP_EN
                    loop_d = data_in[2];
`endif
                    if (data_in[0] && !busy_q) begin
                        state_d = S_LOAD;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        pix_d   = 4'd0;
                        last_d  = eff_m1[3:0];
                    end
                end
                4'h1: begin
                    if (busy_q)              err_d   = 1'b1;
                    else if (data_in < NL8)  index_d = data_in[3:0];
                    else                     index_d = 4'd0;
                end
                4'h2: begin
                    if (busy_q) err_d = 1'b1;
                    else        g_d   = data_in;
                end
                4'h3: begin
                    if (busy_q) err_d = 1'b1;
                    else        r_d   = data_in;
                end
                4'h4: begin
                    if (busy_q) err_d = 1'b1;
                    else begin
                        buf_we  = 1'b1;
                        index_d = (index_q == LAST_IX) ? 4'd0 : index_q + 4'd1;
                    end
                end
                4'h5: begin
                    if (busy_q) err_d   = 1'b1;
                    else        count_d = data_in;
                end
                default: ;
            endcase
        end

        case (state_q)
            S_LOAD: begin
                shift_d = buf_q[pix_q];
                bitn_d  = 5'd0;
                tmr_d   = '0;
                state_d = S_BIT;
            end
            S_BIT: begin
                led_d = (tmr_q < thigh);
                if (tmr_q == TW'(TBIT - 1)) begin
                    tmr_d = '0;
                    if (bitn_q == 5'd23) begin
                        if (pix_q == last_q) begin
                            state_d = S_LATCH;
                        end else begin
                            pix_d   = pix_q + 4'd1;
                            state_d = S_LOAD;
                        end
                    end else begin
                        bitn_d  = bitn_q + 5'd1;
                        shift_d = {shift_q[22:0], 1'b0};
                    end
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_LATCH: begin
                if (tmr_q == TW'(TRST - 1)) begin
                    tmr_d  = '0;
                    done_d = 1'b1;
                    if (loop_q) begin
                        pix_d   = 4'd0;
                        state_d = S_LOAD;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            loop_q  <= 1'b0;
            index_q <= 4'd0;
            count_q <= 8'd0;
            g_q     <= 8'd0;
            r_q     <= 8'd0;
            pix_q   <= 4'd0;
            last_q  <= 4'd0;
            shift_q <= 24'd0;
            bitn_q  <= 5'd0;
            tmr_q   <= '0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            loop_q  <= loop_d;
            index_q <= index_d;
            count_q <= count_d;
            g_q     <= g_d;
            r_q     <= r_d;
            pix_q   <= pix_d;
            last_q  <= last_d;
            shift_q <= shift_d;
            bitn_q  <= bitn_d;
            tmr_q   <= tmr_d;
            led_q   <= led_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)      buf_q          <= '0;
        else if (buf_we) buf_q[index_q] <= buf_wdata;
    end

    // Registered line driver keeps the LED data pin glitch-free.
    assign uo_out = {6'b0, led_q, 1'b0};

    always_comb begin
        data_out = 8'h00;
        case (address)
            4'h0:    data_out = {5'b0, err_q, done_q, busy_q};
            4'h1:    data_out = {4'b0, index_q};
            4'h5:    data_out = count_q;
            4'h6:    data_out = ui_in;
            default: data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_ws2812b_ctrl.sv
// Bench for ws2812b_ctrl: register table vectors plus a bit-level scoreboard on the LED line.
module tb_ws2812b_ctrl;
    localparam int NL   = 8;
    localparam int T0H  = 26;
    localparam int T1H  = 51;
    localparam int TBIT = 80;
    localparam int TRST = 19200;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;

    ws2812b_ctrl #(.NUM_LEDS(NL), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRST(TRST)) dut (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
        .address(address), .data_write(data_write), .data_in(data_in), .data_out(data_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard of expected bits on the LED line
    typedef struct { logic bitv; logic first; } exp_bit_t;
    exp_bit_t sbq[$];
    bit  mon_en = 1'b1;
    int  pulses = 0;
    int  last_rise = 0;

    task automatic push_pixel(input logic [23:0] px, input int nbits);
        for (int i = 23; i > 23 - nbits; i--) sbq.push_back('{px[i], (i == 23)});
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        logic     prev;
        int       rise_cyc;
        exp_bit_t e;
        prev = 1'b0;
        rise_cyc = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (uo_out[1] && !prev) begin
                    if (sbq.size() > 0 && !sbq[0].first) check("bit_period", cyc - last_rise, TBIT);
                    last_rise = cyc;
                    rise_cyc  = cyc;
                end
                if (!uo_out[1] && prev) begin
                    if (sbq.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_pulse: got width %0d, expected no pulse (cycle %0d)", cyc - rise_cyc, cyc);
                    end else begin
                        e = sbq.pop_front();
                        check("bit_high", cyc - rise_cyc, e.bitv ? T1H : T0H);
                        check("uo_low_between", uo_out, 0);
                        pulses++;
                    end
                end
            end
            prev = uo_out[1];
        end
    end

    // Bench-side register model for idle writes
    logic [23:0] mdl_buf [NL];
    int          mdl_idx = 0;
    logic [7:0]  mdl_g = 0, mdl_r = 0, mdl_cnt = 0;

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        @(negedge clk);
        data_write = 1'b0;
    endtask

    task automatic wrm(input logic [3:0] a, input logic [7:0] d);
        wr(a, d);
        case (a)
            4'h1: mdl_idx = (int'(d) < NL) ? int'(d) : 0;
            4'h2: mdl_g = d;
            4'h3: mdl_r = d;
            4'h4: begin
                mdl_buf[mdl_idx] = {mdl_g, mdl_r, d};
                mdl_idx = (mdl_idx == NL - 1) ? 0 : mdl_idx + 1;
            end
            4'h5: mdl_cnt = d;
            default: ;
        endcase
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] v);
        address = a;
        #1;
        v = data_out;
    endtask

    task automatic wait_done(input int limit, input string name);
        logic [7:0] s;
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            rd(4'h0, s);
            if (s[1]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: got no done within %0d cycles, expected done=1", name, limit);
        end
    endtask

    typedef struct {
        logic [3:0] wa;
        logic [7:0] wd;
        logic       wen;
        logic [3:0] ra;
        logic [7:0] exp;
    } vec_t;
    vec_t vt[12];

    initial begin
        logic [7:0] v;
        int         d;
        bit         hit;
        logic [7:0] ctrl_start;

        vt[0]  = '{4'h1, 8'h03, 1'b1, 4'h1, 8'h03};
        vt[1]  = '{4'h1, 8'h08, 1'b1, 4'h1, 8'h00};
        vt[2]  = '{4'h1, 8'h05, 1'b1, 4'h1, 8'h05};
        vt[3]  = '{4'h1, 8'hFF, 1'b1, 4'h1, 8'h00};
        vt[4]  = '{4'h1, 8'h07, 1'b1, 4'h1, 8'h07};
        vt[5]  = '{4'h5, 8'h20, 1'b1, 4'h5, 8'h20};
        vt[6]  = '{4'h5, 8'h00, 1'b1, 4'h5, 8'h00};
        vt[7]  = '{4'h0, 8'h00, 1'b0, 4'h6, 8'h5A};
        vt[8]  = '{4'h0, 8'h00, 1'b0, 4'h7, 8'h00};
        vt[9]  = '{4'h2, 8'h34, 1'b1, 4'h2, 8'h00};
        vt[10] = '{4'h3, 8'h56, 1'b1, 4'h1, 8'h07};
        vt[11] = '{4'h0, 8'h00, 1'b0, 4'hF, 8'h00};
        for (int i = 0; i < NL; i++) mdl_buf[i] = 24'h0;

`ifdef WS2812_LOOP_EN
        ctrl_start = 8'h01;
`else
        ctrl_start = 8'h05;
`endif

        rst_n = 1'b0; ui_in = 8'h5A; address = 4'h0; data_write = 1'b0; data_in = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_uo_out", uo_out, 0);
        rd(4'h0, v); check("rst_status", v, 0);
        rd(4'h1, v); check("rst_index", v, 0);
        rd(4'h5, v); check("rst_count", v, 0);

        for (int i = 0; i < 12; i++) begin
            if (vt[i].wen) wrm(vt[i].wa, vt[i].wd);
            else           @(negedge clk);
            rd(vt[i].ra, v);
            check($sformatf("vec%0d", i), v, vt[i].exp);
        end

        // Single pixel FF00AA with COUNT=1
        wrm(4'h1, 8'h00); wrm(4'h2, 8'hFF); wrm(4'h3, 8'h00); wrm(4'h4, 8'hAA);
        wrm(4'h5, 8'h01);
        pulses = 0;
        push_pixel(24'hFF00AA, 24);
        wr(4'h0, 8'h01);
        rd(4'h0, v); check("busy_after_start", v, 8'h01);
        wait_done(TBIT * 24 + TRST + 100, "single_frame_done");
        d = cyc - last_rise;
        check("latch_gap_in_window", int'(d >= TBIT + TRST - 1 && d <= TBIT + TRST + 1), 1);
        check("single_frame_bits", pulses, 24);
        rd(4'h0, v); check("done_status", v, 8'h02);
        wr(4'h0, 8'h02);
        rd(4'h0, v); check("clear_done", v, 8'h00);

        // Three pixels wrapping from the last slot
        wrm(4'h1, 8'(NL - 1));
        wrm(4'h2, 8'h11); wrm(4'h3, 8'h22); wrm(4'h4, 8'h33);
        wrm(4'h2, 8'h44); wrm(4'h3, 8'h55); wrm(4'h4, 8'h66);
        wrm(4'h2, 8'h77); wrm(4'h3, 8'h88); wrm(4'h4, 8'h99);
        rd(4'h1, v); check("index_wrapped", v, 8'h02);

        // Full strip with COUNT=0, busy-write error handling
        wrm(4'h5, 8'h00);
        pulses = 0;
        for (int p = 0; p < NL; p++) push_pixel(mdl_buf[p], 24);
        wr(4'h0, ctrl_start);
        rd(4'h0, v); check("busy_full", v, 8'h01);
        wr(4'h2, 8'h12);
        rd(4'h0, v); check("err_on_busy_g", v, 8'h05);
        wr(4'h1, 8'h05);
        rd(4'h1, v); check("index_locked", v, 8'h02);
        wr(4'h4, 8'hEE);
        wr(4'h0, 8'h01);
        rd(4'h0, v); check("restart_ignored", v, 8'h05);
        wait_done(TBIT * 24 * NL + NL + TRST + 200, "full_frame_done");
        check("full_frame_bits", pulses, 24 * NL);
        check("queue_drained", sbq.size(), 0);
        rd(4'h0, v); check("done_err_status", v, 8'h06);

        // Clear+start together, then reset mid-frame at bit 10 of pixel 2
        pulses = 0;
        push_pixel(mdl_buf[0], 24);
        push_pixel(mdl_buf[1], 24);
        push_pixel(mdl_buf[2], 10);
        wr(4'h0, 8'h03);
        rd(4'h0, v); check("clear_then_start", v, 8'h01);
        hit = 1'b0;
        for (int k = 0; k < TBIT * 24 * 3; k++) begin
            @(negedge clk);
            if (pulses == 58 && uo_out[1]) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) begin
            n_chk++;
            n_fail++;
            $display("FAIL reset_point: got %0d pulses, expected to reach bit 10 of pixel 2", pulses);
        end
        mon_en = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        check("abort_uo_low", uo_out, 0);
        rd(4'h0, v); check("abort_status", v, 0);
        rd(4'h1, v); check("abort_index", v, 0);
        check("abort_bits_sent", pulses, 58);
        rst_n = 1'b1;
        sbq.delete();
        @(negedge clk);
        rd(4'h5, v); check("abort_count", v, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ws2812b_ctrl.md
WS2812B_CTRL -- requirements
Module: ws2812b_ctrl

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8, pixel buffer depth (1..16).
REQ-002 SHALL have parameter T0H, default 26, clk cycles high for a 0 bit.
REQ-003 SHALL have parameter T1H, default 51, clk cycles high for a 1 bit.
REQ-004 SHALL have parameter TBIT, default 80, clk cycles per bit period.
REQ-005 SHALL have parameter TRST, default 19200, clk cycles of low latch time.
REQ-006 SHALL have port clk  input  1  clock.
REQ-007 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port ui_in  input  8  input PMOD, readable only.
REQ-009 SHALL have port uo_out  output  8  bit1 = LED data out, all other bits 0.
REQ-010 SHALL have port address  input  4  register select.
REQ-011 SHALL have port data_write  input  1  write strobe, one cycle.
REQ-012 SHALL have port data_in  input  8  write data.
REQ-013 SHALL have port data_out  output  8  combinational read data for address.

Function
REQ-014 SHALL decode writes: 0x0 CTRL (bit0 start, bit1 clear flags, bit2 loop), 0x1 INDEX, 0x2 G, 0x3 R, 0x4 B, 0x5 COUNT.
REQ-015 SHALL decode reads: 0x0 {5'b0, err, done, busy}, 0x1 INDEX, 0x5 COUNT, 0x6 ui_in, others 0x00.
REQ-016 SHALL stage G and R writes; a B write SHALL commit {G,R,B} to buffer[INDEX] and increment INDEX, wrapping NUM_LEDS-1 -> 0.
REQ-017 SHALL store INDEX writes >= NUM_LEDS as 0.
REQ-018 SHALL treat COUNT of 0 or > NUM_LEDS as NUM_LEDS when starting a frame.
REQ-019 SHALL run FSM IDLE -> LOAD -> BIT -> LATCH -> IDLE.
REQ-020 IDLE: on CTRL write with bit0=1, SHALL go to LOAD next cycle, busy=1, done=0.
REQ-021 LOAD: SHALL latch buffer[pix] into a 24-bit shift register, go to BIT; takes exactly 1 cycle.
REQ-022 BIT: SHALL drive data high for T1H (bit=1) or T0H (bit=0) cycles, then low to TBIT total, MSB first (G7..B0).
REQ-023 After 24 bits SHALL go to LOAD for next pixel, or LATCH after pixel COUNT-1; no gap between pixels other than the LOAD cycle.
REQ-024 LATCH: SHALL hold data low TRST cycles, then set done=1, busy=0, go IDLE.
REQ-025 Start while busy SHALL be ignored.
REQ-026 G/R/B/INDEX/COUNT writes while busy SHALL be ignored and SHALL set sticky err.
REQ-027 CTRL bit1=1 SHALL clear done and err; simultaneous with start, clear applies first, then start.
REQ-028 Data output SHALL be low whenever not in BIT high phase.

Reset
REQ-029 On rst_n=0 at clk edge SHALL set FSM IDLE, busy/done/err/loop 0, INDEX 0, COUNT 0, staging 0, uo_out 0x00.
REQ-030 Reset mid-frame SHALL abort immediately, output low next cycle; buffer contents SHALL be reset to 0.

Configuration
REQ-031 Macro WS2812_LOOP_EN defined: CTRL bit2 stored; at LATCH end with loop=1 SHALL return to LOAD pixel 0, done pulses set, busy stays 1; writing loop=0 ends after current frame.
REQ-032 WS2812_LOOP_EN undefined: CTRL bit2 ignored, always single frame.

Verification
REQ-033 INDEX=0, G=0xFF,R=0x00,B=0xAA, COUNT=1, start -> 24 bits: 8x51-high, 8x26-high, 10101010 pattern; period 80 each; then 19200 low; done=1.
REQ-034 Write 3 pixels from INDEX=NUM_LEDS-1 -> INDEX reads 2; buffer[7],[0],[1] hold data.
REQ-035 Start, then write G=0x12 while busy -> err=1, buffer unchanged; CTRL 0x02 -> err=0.
REQ-036 COUNT=0, NUM_LEDS=8 -> exactly 192 bits then latch.
REQ-037 rst_n low at bit 10 of pixel 2 -> uo_out 0x00 next cycle, busy=0, INDEX 0.
REQ-038 WS2812_LOOP_EN, COUNT=2, CTRL 0x05 -> frames repeat with 19200-cycle latch; CTRL 0x00 -> stops after current frame, busy=0.
